keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Upstream stage of the door-lock operational block: scans a 4x4 matrix keypad, synchronises and debounces the column lines, and presents one debounced key as a level key_valid plus a stable 4-bit key_code.
- The consumer edge-detects key_valid, so this block guarantees exactly one rising edge per physical press (plus repeats when the optional feature is compiled in).
- Runs on the 1 kHz system clock.

Parameters:
- SCAN_CYCLES, 2: cycles each row is driven before its columns are sampled (settling time); legal range >= 1.
- DEBOUNCE_CYCLES, 20: consecutive stable cycles required to accept a press and, separately, to accept a release; legal range >= 1.
- REPEAT_CYCLES, 500: hold time before each auto-repeat. Used only with KEYPAD_REPEAT_EN.

Ports:
- clk  in  1  system clock (1 kHz)
- rst  in  1  asynchronous, active-low reset (block is in reset while rst == 0)
- enable  in  1  scanning allowed; 0 forces idle
- col_n  in  4  keypad columns, active-low, asynchronous to clk, externally pulled up
- row_n  out  4  keypad rows, active-low, at most one bit low at a time
- key_valid  out  1  high while a debounced key is held
- key_code  out  4  code of the last accepted key, stable while key_valid is high

Behaviour:
- Reset values:
  - row_n = 4'b1110 (row 0 driven)
  - key_valid = 0, key_code = 4'h0
  - state = SCAN, row index = 0, all counters = 0
  - col synchroniser flops = 4'b1111
- Synchroniser: col_n passes through 2 flip-flops to give col_s. All decisions use col_s only.
- Key map [row][col], row 0..3, col 0..3:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: * 0 # D
  - Digits map to their own value; A-D map to 4'hA-4'hD; * maps to 4'hE; # (enter) maps to 4'hF.
- State SCAN:
  - Drive the current row low. The timer counts 0..SCAN_CYCLES-1.
  - On the last timer cycle, sample col_s:
    - Exactly one bit low: latch that column pattern and its decoded code, go to DEBOUNCE. row_n stays frozen.
    - Zero bits low, or two or more bits low (ghosting): advance the row index (3 wraps to 0) and restart the timer.
- State DEBOUNCE:
  - row_n stays frozen. Each cycle, compare col_s with the latched pattern.
  - Mismatch: go to SCAN on the next row; key_valid stays 0.
  - DEBOUNCE_CYCLES consecutive matches: next cycle key_valid = 1 and key_code = latched code; go to HELD.
- State HELD:
  - row_n stays frozen; key_valid = 1.
  - Release is col_s == 4'b1111. A release counter increments on each release cycle and is cleared on any non-release cycle (bounce, or a different key).
  - At DEBOUNCE_CYCLES consecutive release cycles: key_valid = 0, go to SCAN on the next row.
  - A second key pressed while holding is ignored; the first key keeps key_valid high until everything is released.
- enable:
  - enable = 0 in any state: next cycle row_n = 4'b1111, key_valid = 0, state = SCAN, row index = 0, counters cleared. key_code keeps its value.
  - enable 0->1: scanning starts at row 0.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous).
- Latency: a clean press sampled at the end of a row slot gives key_valid high DEBOUNCE_CYCLES+1 cycles later, plus 2 synchroniser cycles counted from the pin.
- key_code changes only on the cycle key_valid rises.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter counts cycles while the key stays pressed.
  - At REPEAT_CYCLES it drives key_valid low for exactly 1 cycle, then high again (a new rising edge, same key_code), and restarts the counter.
  - The repeat counter clears on any release cycle.
- Undefined: no repeat logic; key_valid stays continuously high through HELD.

Test Plan (SCAN_CYCLES=2, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10):
- Reset: rst=0 -> row_n=4'b1110, key_valid=0, key_code=0. rst=1, no key -> row_n cycles 1110, 1101, 1011, 0111, 1110 with 2 cycles per row.
- Clean press of '#' (row 3, col 2): hold col_n=4'b1011 while row 3 is driven -> key_valid rises once, key_code=4'hF, row_n stays 0111. Release for 4 cycles -> key_valid=0, scanning resumes at row 0.
- Bounce on '5': col_n toggles every 2 cycles during DEBOUNCE -> key_valid never rises. Then hold stable -> key_valid=1, key_code=4'h5.
- Ghost press: two columns low in one row -> no DEBOUNCE entry, row advances, key_valid=0. Release glitch in HELD of 3 cycles released then pressed -> key_valid stays 1.
- enable=0 during HELD -> next cycle key_valid=0, row_n=4'b1111. enable=1 -> row_n=4'b1110. Async rst=0 mid-DEBOUNCE -> all outputs at reset values.
- KEYPAD_REPEAT_EN defined, hold '7' for 25 cycles after accept -> key_valid low for exactly 1 cycle at holds 10 and 20 (counted from the cycle key_valid first rises), key_code=4'h7 throughout. Undefined -> no drop.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row walk, 2-flop column synchroniser, press/release debounce.
// Optional auto-repeat while a key is held: compile with KEYPAD_REPEAT_EN defined.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 2,
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_CYCLES   = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [3:0] col_n,
  output logic [3:0] row_n,
  output logic       key_valid,
  output logic [3:0] key_code
);

  if (SCAN_CYCLES < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("keypad_scanner: SCAN_CYCLES, DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
  end

  localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t            state, state_d;
  logic [1:0]        row_idx, row_idx_d;
  logic [SCAN_W-1:0] timer, timer_d;
  logic [DEB_W-1:0]  deb_cnt, deb_cnt_d;
  logic [DEB_W-1:0]  rel_cnt, rel_cnt_d;
  logic [3:0]        pat, pat_d;
  logic [3:0]        pend_code, pend_code_d;
  logic [3:0]        row_n_d, key_code_d;
  logic              key_valid_d;
  logic [3:0]        col_m, col_s;
  logic [3:0]        col_low;
  logic              col_single;
  logic [1:0]        col_idx;
  logic              advance;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt, rep_cnt_d;
`endif

  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // Keypad legend: * reads as E, # (enter) as F.
  function automatic logic [3:0] decode_key(input logic [1:0] row, input logic [1:0] col);
    case ({row, col})
      4'b00_00: return 4'h1;  4'b00_01: return 4'h2;  4'b00_10: return 4'h3;  4'b00_11: return 4'hA;
      4'b01_00: return 4'h4;  4'b01_01: return 4'h5;  4'b01_10: return 4'h6;  4'b01_11: return 4'hB;
      4'b10_00: return 4'h7;  4'b10_01: return 4'h8;  4'b10_10: return 4'h9;  4'b10_11: return 4'hC;
      4'b11_00: return 4'hE;  4'b11_01: return 4'h0;  4'b11_10: return 4'hF;  default:  return 4'hD;
    endcase
  endfunction

  // Columns are asynchronous to clk; nothing downstream looks at col_n directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_m <= 4'b1111;
      col_s <= 4'b1111;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its source.
      col_m <= col_n;
      col_s <= col_m;
    end
  end

  // Exactly one low column is a valid press; two or more is ghosting.
  assign col_low    = ~col_s;
  assign col_single = (col_low != 4'd0) && ((col_low & (col_low - 4'd1)) == 4'd0);

  always_comb begin
    case (col_s)
      4'b1110: col_idx = 2'd0;
      4'b1101: col_idx = 2'd1;
      4'b1011: col_idx = 2'd2;
      default: col_idx = 2'd3;
    endcase
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no latch is inferred.
    state_d     = state;
    row_idx_d   = row_idx;
    timer_d     = timer;
    deb_cnt_d   = deb_cnt;
    rel_cnt_d   = rel_cnt;
    pat_d       = pat;
    pend_code_d = pend_code;
    row_n_d     = row_n;
    key_valid_d = key_valid;
    key_code_d  = key_code;
    advance     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d   = rep_cnt;
`endif

    if (!enable) begin
      state_d     = SCAN;
      row_idx_d   = 2'd0;
      timer_d     = '0;
      deb_cnt_d   = '0;
      rel_cnt_d   = '0;
      row_n_d     = 4'b1111;
      key_valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_d   = '0;
`endif
    end else begin
      case (state)
        SCAN: begin
          if (row_n == 4'b1111) begin
            // Leaving idle: drive row 0 first so its slot gets the full settling time.
            row_n_d = row_drive(row_idx);
          end else if (timer == SCAN_LAST) begin
            if (col_single) begin
              pat_d       = col_s;
              pend_code_d = decode_key(row_idx, col_idx);
              deb_cnt_d   = '0;
              state_d     = DEBOUNCE;
            end else begin
              advance = 1'b1;
            end
          end else begin
            timer_d = timer + SCAN_W'(1);
          end
        end
        DEBOUNCE: begin
          if (col_s != pat) begin
            advance = 1'b1;
          end else if (deb_cnt == DEB_LAST) begin
            state_d     = HELD;
            key_valid_d = 1'b1;
            key_code_d  = pend_code;
            rel_cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_d   = '0;
`endif
          end else begin
            deb_cnt_d = deb_cnt + DEB_W'(1);
          end
        end
        HELD: begin
          if (col_s == 4'b1111) begin
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_d = '0;
`endif
            if (rel_cnt == DEB_LAST) begin
              key_valid_d = 1'b0;
              advance     = 1'b1;
            end else begin
              rel_cnt_d   = rel_cnt + DEB_W'(1);
              key_valid_d = 1'b1;
            end
          end else begin
            // Any contact, including a second key, restarts the release count.
            rel_cnt_d = '0;
`ifdef KEYPAD_REPEAT_EN
            if (rep_cnt == REP_LAST) begin
              key_valid_d = 1'b0;
              rep_cnt_d   = '0;
            end else begin
              key_valid_d = 1'b1;
              rep_cnt_d   = rep_cnt + REP_W'(1);
            end
`else
            key_valid_d = 1'b1;
`endif
          end
        end
        default: state_d = SCAN;
      endcase

      if (advance) begin
        state_d   = SCAN;
        row_idx_d = row_idx + 2'd1;
        row_n_d   = row_drive(row_idx + 2'd1);
        timer_d   = '0;
        deb_cnt_d = '0;
        rel_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= SCAN;
      row_idx   <= 2'd0;
      timer     <= '0;
      deb_cnt   <= '0;
      rel_cnt   <= '0;
      pat       <= 4'b1111;
      pend_code <= 4'h0;
      row_n     <= 4'b1110;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= '0;
`endif
    end else begin
      state     <= state_d;
      row_idx   <= row_idx_d;
      timer     <= timer_d;
      deb_cnt   <= deb_cnt_d;
      rel_cnt   <= rel_cnt_d;
      pat       <= pat_d;
      pend_code <= pend_code_d;
      row_n     <= row_n_d;
      key_valid <= key_valid_d;
      key_code  <= key_code_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt   <= rep_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: cycle model built on absolute cycle stamps,
// directed scenarios with literal expectations, then randomized column traffic.
module tb_keypad_scanner;
  localparam int S = 2;
  localparam int D = 4;
  localparam int R = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] col_n = 4'hF;
  logic [3:0] row_n;
  logic       key_valid;
  logic [3:0] key_code;

  keypad_scanner #(.SCAN_CYCLES(S), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .enable(enable), .col_n(col_n),
    .row_n(row_n), .key_valid(key_valid), .key_code(key_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 walking rows, 1 confirming a press, 2 key held. Timing is kept as
  // absolute cycle stamps rather than counters.
  int         cyc = 0;
  int         m_phase, m_row, slot_start, deb_start, rel_start, rep_base;
  bit         m_idle;
  logic [3:0] m_s1, m_s2, m_pat, m_pend, m_code, m_row_n;
  logic       m_kv;

  function automatic logic [3:0] key_of(input int row, input int col);
    if (col == 3) return 4'(10 + row);
    if (row < 3)  return 4'(row * 3 + col + 1);
    return (col == 0) ? 4'hE : (col == 1) ? 4'h0 : 4'hF;
  endfunction

  task automatic model_next_row(input int now);
    m_phase    = 0;
    m_row      = (m_row + 1) % 4;
    slot_start = now + 1;
  endtask

  task automatic model_reset();
    m_s1 = 4'hF; m_s2 = 4'hF;
    m_phase = 0; m_row = 0; m_idle = 0;
    m_kv = 1'b0; m_code = 4'h0;
    slot_start = cyc;
    m_row_n = 4'b1110;
  endtask

  task automatic model_step();
    int now;
    int col;
    logic [3:0] cs;
    now = cyc;
    cs = m_s2;
    m_s2 = m_s1;
    m_s1 = col_n;
    if (!enable) begin
      m_phase = 0; m_row = 0; m_idle = 1; m_kv = 1'b0;
      slot_start = now + 1;
    end else if (m_phase == 0) begin
      if (m_idle) begin
        m_idle = 0;
        slot_start = now + 1;
      end else if (now - slot_start == S - 1) begin
        if ($countones(~cs) == 1) begin
          col = 0;
          for (int c = 0; c < 4; c++) if (!cs[c]) col = c;
          m_pat = cs;
          m_pend = key_of(m_row, col);
          m_phase = 1;
          deb_start = now + 1;
        end else begin
          model_next_row(now);
        end
      end
    end else if (m_phase == 1) begin
      if (cs != m_pat) model_next_row(now);
      else if (now - deb_start == D - 1) begin
        m_phase = 2; m_kv = 1'b1; m_code = m_pend;
        rel_start = -1; rep_base = now + 1;
      end
    end else begin
      if (cs == 4'hF) begin
        if (rel_start < 0) rel_start = now;
        rep_base = now + 1;
        if (now - rel_start == D - 1) begin
          m_kv = 1'b0;
          model_next_row(now);
        end else m_kv = 1'b1;
      end else begin
        rel_start = -1;
`ifdef KEYPAD_REPEAT_EN
        if (now - rep_base == R - 1) begin
          m_kv = 1'b0;
          rep_base = now + 1;
        end else m_kv = 1'b1;
`else
        m_kv = 1'b1;
`endif
      end
    end
    m_row_n = m_idle ? 4'hF : ~(4'b0001 << m_row);
    cyc++;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else model_step();
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("row_n", row_n, m_row_n);
      check("key_valid", key_valid, m_kv);
      check("key_code", key_code, m_code);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the last cycle of the row before `row`, so that with the two-cycle
  // synchroniser a pattern applied now is first sampled in `row`'s slot.
  task automatic align_to(input int row);
    logic [3:0] one;
    logic [3:0] prev;
    int t;
    one = 4'b0001;
    prev = ~(one << ((row + 3) % 4));
    t = 0;
    while (row_n == prev && t < 60) begin @(negedge clk); t++; end
    while (row_n != prev && t < 60) begin @(negedge clk); t++; end
    @(negedge clk);
    if (t >= 60) check("align_timeout", 0, 1);
  endtask

  logic [3:0] walk [9] = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7, 4'hE};

  initial begin
    bit         flag;
    logic [3:0] seen;
    logic       exp_kv;

    // Reset state
    wait_n(3);
    check("reset_row_n", row_n, 4'b1110);
    check("reset_key_valid", key_valid, 1'b0);
    check("reset_key_code", key_code, 4'h0);
    cmp_en = 1;
    rst = 1'b1;

    // Idle row walk, two cycles per row
    check("walk_0", row_n, walk[0]);
    for (int i = 1; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("walk_%0d", i), row_n, walk[i]);
    end

    // Clean press of '#' (row 3, column 2)
    align_to(3);
    col_n = 4'b1011;
    wait_n(6);
    check("hash_before_accept", key_valid, 1'b0);
    wait_n(1);
    check("hash_accept_kv", key_valid, 1'b1);
    check("hash_code", key_code, 4'hF);
    check("hash_row_frozen", row_n, 4'b0111);
    wait_n(3);
    col_n = 4'hF;
    wait_n(5);
    check("hash_release_pending", key_valid, 1'b1);
    wait_n(1);
    check("hash_released", key_valid, 1'b0);
    check("hash_next_row", row_n, 4'b1110);

    // Bouncing '5' never accepted, then a stable press is
    align_to(1);
    flag = 0;
    for (int i = 0; i < 6; i++) begin
      col_n = (i % 2 == 0) ? 4'b1101 : 4'hF;
      repeat (2) begin @(negedge clk); if (key_valid) flag = 1; end
    end
    check("bounce_no_accept", flag, 1'b0);
    col_n = 4'hF;
    wait_n(4);
    align_to(1);
    col_n = 4'b1101;
    wait_n(7);
    check("five_accept_kv", key_valid, 1'b1);
    check("five_code", key_code, 4'h5);
    col_n = 4'hF;
    wait_n(8);
    check("five_released", key_valid, 1'b0);

    // Ghosting: two columns low is never a press
    col_n = 4'b1100;
    seen = 4'h0;
    flag = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | ~row_n;
      if (key_valid) flag = 1;
    end
    check("ghost_no_accept", flag, 1'b0);
    check("ghost_rows_advance", seen, 4'hF);
    col_n = 4'hF;
    wait_n(4);

    // Release glitch of 3 cycles while holding '1'
    align_to(0);
    col_n = 4'b1110;
    wait_n(7);
    check("one_accept_kv", key_valid, 1'b1);
    check("one_code", key_code, 4'h1);
    col_n = 4'hF;
    flag = 0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 3) col_n = 4'b1110;
      if (!key_valid) flag = 1;
    end
    check("glitch_hold", flag, 1'b0);

    // enable low while held
    enable = 1'b0;
    col_n = 4'hF;
    wait_n(1);
    check("disable_kv", key_valid, 1'b0);
    check("disable_row_n", row_n, 4'hF);
    check("disable_code_kept", key_code, 4'h1);
    wait_n(1);
    enable = 1'b1;
    wait_n(1);
    check("enable_row0", row_n, 4'b1110);
    wait_n(2);
    check("enable_row1", row_n, 4'b1101);

    // Asynchronous reset in the middle of a debounce
    align_to(2);
    col_n = 4'b0111;
    wait_n(4);
    #2 rst = 1'b0;
    #1;
    check("async_rst_row_n", row_n, 4'b1110);
    check("async_rst_kv", key_valid, 1'b0);
    check("async_rst_code", key_code, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    col_n = 4'hF;
    wait_n(4);

    // Long hold of '7': repeats only when the feature is compiled in
    align_to(2);
    col_n = 4'b1110;
    wait_n(7);
    check("seven_accept_kv", key_valid, 1'b1);
    for (int h = 1; h <= 25; h++) begin
      @(negedge clk);
`ifdef KEYPAD_REPEAT_EN
      exp_kv = (h == 10 || h == 20) ? 1'b0 : 1'b1;
`else
      exp_kv = 1'b1;
`endif
      check($sformatf("seven_hold_%0d_kv", h), key_valid, exp_kv);
      check($sformatf("seven_hold_%0d_code", h), key_code, 4'h7);
    end
    col_n = 4'hF;
    wait_n(10);

    // Randomized column traffic, checked by the model every cycle
    for (int it = 0; it < 60; it++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 4) col_n = 4'hF;
      else if (sel < 9) col_n = ~(4'b0001 << $urandom_range(0, 3));
      else col_n = 4'($urandom_range(0, 15));
      enable = ($urandom_range(0, 19) != 0);
      wait_n($urandom_range(1, 30));
    end
    enable = 1'b1;
    col_n = 4'hF;
    wait_n(12);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
